// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// requester and the data requester. A request is latched onto the RAM port
// until the RAM signals completion, or until a timeout aborts it. On a
// timeout the sticky bus_err flag is raised and the request is arbitrated
// again.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    // Counter value seen in the last allowed access cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic       last_d_q;
    logic [7:0] cnt_q;

    logic       dreq_s;
    logic       idone_s;
    logic       ddone_s;

    // Request decode and completion detection (ram_ready may feed wait/load only).
    always_comb begin
        dreq_s  = dREN | dWEN;
        idone_s = (state_q == IACC) && ram_ready;
        ddone_s = (state_q == DACC) && ram_ready;
        iwait   = iREN & ~idone_s;
        dwait   = dreq_s & ~ddone_s;
        if (idone_s && iREN) begin
            iload = ram_load;
        end else begin
            iload = {DATA_W{1'b0}};
        end
        if (ddone_s && dreq_s) begin
            dload = ram_load;
        end else begin
            dload = {DATA_W{1'b0}};
        end
    end

    // Arbitration FSM: grant, hold latched access, complete or time out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            cnt_q     <= 8'd0;
            bus_err   <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_store <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    // Data wins unless it was served last and a fetch is waiting.
                    if (dreq_s && !(last_d_q && iREN)) begin
                        state_q   <= DACC;
                        ram_addr  <= daddr;
                        ram_store <= dstore;
                        ram_wen   <= dWEN;
                        ram_ren   <= ~dWEN;
                    end else if (iREN) begin
                        state_q  <= IACC;
                        ram_addr <= iaddr;
                        ram_ren  <= 1'b1;
                        ram_wen  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                    end
                end
                IACC, DACC: begin
                    if (ram_ready) begin
                        state_q  <= IDLE;
                        ram_ren  <= 1'b0;
                        ram_wen  <= 1'b0;
                        last_d_q <= (state_q == DACC);
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // Abort; the requester still sees wait=1 and retries.
                        state_q <= IDLE;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ram_ren <= 1'b0;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT = 4). Inputs change 2 time
// units after a rising edge; outputs are checked 1 time unit later.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // Global time guard.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_addr [4];
        logic        exp_is_d [4];
        exp_addr[0] = 32'h180; exp_is_d[0] = 1'b1;
        exp_addr[1] = 32'h080; exp_is_d[1] = 1'b0;
        exp_addr[2] = 32'h180; exp_is_d[2] = 1'b1;
        exp_addr[3] = 32'h080; exp_is_d[3] = 1'b0;

        nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ram_load = 32'h0; ram_ready = 1'b0;

        // ---- Reset state ----
        cyc();
        #1;
        chk("rst_ren", 32'(ram_ren), 32'd0);
        chk("rst_wen", 32'(ram_wen), 32'd0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_store", ram_store, 32'h0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        iREN = 1'b1; dREN = 1'b1;
        #1;
        chk("rst_iwait_follow", 32'(iwait), 32'd1);
        chk("rst_dwait_follow", 32'(dwait), 32'd1);
        iREN = 1'b0; dREN = 1'b0;
        cyc();
        nRST = 1'b1;

        // ---- Single instruction fetch ----
        cyc();
        iREN = 1'b1; iaddr = 32'h40;
        #1;
        chk("if_wait_pre", 32'(iwait), 32'd1);
        chk("if_ren_pre", 32'(ram_ren), 32'd0);
        cyc();
        chk("if_ren", 32'(ram_ren), 32'd1);
        chk("if_addr", ram_addr, 32'h40);
        ram_ready = 1'b1; ram_load = 32'h8C010004;
        #1;
        chk("if_wait_done", 32'(iwait), 32'd0);
        chk("if_load", iload, 32'h8C010004);
        cyc();
        iREN = 1'b0; ram_ready = 1'b0;
        #1;
        chk("if_idle_ren", 32'(ram_ren), 32'd0);
        chk("if_idle_load", iload, 32'h0);

        // ---- Simultaneous requests, data first ----
        iREN = 1'b1; iaddr = 32'h44;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        #1;
        chk("sim_iwait0", 32'(iwait), 32'd1);
        chk("sim_dwait0", 32'(dwait), 32'd1);
        cyc();
        #1;
        chk("sim_wen", 32'(ram_wen), 32'd1);
        chk("sim_ren", 32'(ram_ren), 32'd0);
        chk("sim_addr", ram_addr, 32'h100);
        chk("sim_store", ram_store, 32'hDEADBEEF);
        chk("sim_iwait1", 32'(iwait), 32'd1);
        cyc();
        ram_ready = 1'b1;
        #1;
        chk("sim_dwait_done", 32'(dwait), 32'd0);
        chk("sim_iwait2", 32'(iwait), 32'd1);
        cyc();
        dWEN = 1'b0; ram_ready = 1'b0;
        #1;
        chk("sim_idle_wen", 32'(ram_wen), 32'd0);
        chk("sim_iwait3", 32'(iwait), 32'd1);
        cyc();
        chk("sim_i_ren", 32'(ram_ren), 32'd1);
        chk("sim_i_addr", ram_addr, 32'h44);
        ram_ready = 1'b1; ram_load = 32'h12345678;
        #1;
        chk("sim_i_wait", 32'(iwait), 32'd0);
        chk("sim_i_load", iload, 32'h12345678);
        cyc();
        iREN = 1'b0; ram_ready = 1'b0;

        // ---- Alternation D, I, D, I ----
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h180;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("alt_addr", ram_addr, exp_addr[k]);
            chk("alt_ren", 32'(ram_ren), 32'd1);
            ram_ready = 1'b1; ram_load = 32'(k + 32'hA0);
            #1;
            chk("alt_iwait", 32'(iwait), 32'(exp_is_d[k]));
            chk("alt_dwait", 32'(dwait), 32'(!exp_is_d[k]));
            chk("alt_load", exp_is_d[k] ? dload : iload, 32'(k + 32'hA0));
            cyc();
            ram_ready = 1'b0;
            #1;
            chk("alt_idle_ren", 32'(ram_ren), 32'd0);
        end
        iREN = 1'b0; dREN = 1'b0;

        // ---- Mid-access change and withdrawal ----
        cyc();
        dREN = 1'b1; daddr = 32'h1F0;
        cyc();
        chk("wd_ren", 32'(ram_ren), 32'd1);
        chk("wd_addr0", ram_addr, 32'h1F0);
        daddr = 32'h200; dREN = 1'b0;
        #1;
        chk("wd_dwait0", 32'(dwait), 32'd0);
        cyc();
        chk("wd_addr1", ram_addr, 32'h1F0);
        chk("wd_ren_hold", 32'(ram_ren), 32'd1);
        ram_ready = 1'b1; ram_load = 32'h55;
        #1;
        chk("wd_dwait1", 32'(dwait), 32'd0);
        chk("wd_no_load", dload, 32'h0);
        cyc();
        ram_ready = 1'b0;
        #1;
        chk("wd_idle_ren", 32'(ram_ren), 32'd0);
        cyc();
        chk("wd_no_regrant", 32'(ram_ren), 32'd0);

        // ---- Timeout (TIMEOUT = 4) ----
        iREN = 1'b1; iaddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("to_ren_high", 32'(ram_ren), 32'd1);
            chk("to_iwait", 32'(iwait), 32'd1);
            chk("to_buserr_low", 32'(bus_err), 32'd0);
        end
        cyc();
        chk("to_ren_low", 32'(ram_ren), 32'd0);
        chk("to_buserr_set", 32'(bus_err), 32'd1);
        chk("to_iwait_retry", 32'(iwait), 32'd1);
        cyc();
        chk("to_regrant", 32'(ram_ren), 32'd1);
        chk("to_regrant_addr", ram_addr, 32'h300);
        ram_ready = 1'b1; ram_load = 32'h0BADF00D;
        #1;
        chk("to_retry_load", iload, 32'h0BADF00D);
        cyc();
        iREN = 1'b0; ram_ready = 1'b0;
        #1;
        chk("to_buserr_sticky", 32'(bus_err), 32'd1);
        chk("to_idle", 32'(ram_ren), 32'd0);

        // ---- Async reset during DACC ----
        dWEN = 1'b1; daddr = 32'h3C0; dstore = 32'hCAFEF00D;
        cyc();
        chk("ar_wen", 32'(ram_wen), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("ar_wen_drop", 32'(ram_wen), 32'd0);
        chk("ar_buserr", 32'(bus_err), 32'd0);
        chk("ar_addr", ram_addr, 32'h0);
        chk("ar_dwait", 32'(dwait), 32'd1);
        #1;
        nRST = 1'b1;
        cyc();
        chk("ar_regrant_wen", 32'(ram_wen), 32'd1);
        chk("ar_regrant_addr", ram_addr, 32'h3C0);
        chk("ar_regrant_store", ram_store, 32'hCAFEF00D);
        ram_ready = 1'b1;
        #1;
        chk("ar_dwait_done", 32'(dwait), 32'd0);
        cyc();
        dWEN = 1'b0; ram_ready = 1'b0;
        #1;
        chk("ar_idle_wen", 32'(ram_wen), 32'd0);
        chk("ar_buserr_end", 32'(bus_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
